// File: rtl/exec_stage_xlen_pkg.sv
// Shared operation types for the execute stage.
//   exec_cmd_e   : 4-bit operation code carried on in_cmd. Codes 14 and 15 are
//                  unassigned and produce a zero result.
//   exec_state_e : execute-stage control state, exported for debug visibility.
// XLEN-dependent widths are not kept here; each module derives its own.
package OpTypes;

    typedef enum logic [3:0] {
        CMD_ADD  = 4'd0,
        CMD_SUB  = 4'd1,
        CMD_SLL  = 4'd2,
        CMD_SLT  = 4'd3,
        CMD_SLTU = 4'd4,
        CMD_XOR  = 4'd5,
        CMD_SRL  = 4'd6,
        CMD_SRA  = 4'd7,
        CMD_OR   = 4'd8,
        CMD_AND  = 4'd9,
        CMD_DIV  = 4'd10,
        CMD_DIVU = 4'd11,
        CMD_REM  = 4'd12,
        CMD_REMU = 4'd13
    } exec_cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } exec_state_e;

endpackage

// File: rtl/exec_stage_xlen_if.sv
// Bus between the execute stage and its neighbours.
//
// Handshake (both sides): a transfer happens on a rising clk edge where valid
// and ready are both 1. valid must not depend on ready. Once out_valid is
// raised, out_value/out_rd stay constant until the transfer completes.
//
//   in_valid/in_ready  : upstream op transfer; in_cmd/in_src1/in_src2/in_rd
//                        are the op payload.
//   flush              : kills the buffered result and any divide in flight.
//   out_valid/out_ready: result transfer; out_value/out_rd are the payload.
//   busy               : divider iterating.
//   state_dbg          : current control state (debug only).
// master = the side driving ops in (upstream + downstream), slave = the stage.
interface exec_stage_xlen_if #(parameter int XLEN = 32);
    import OpTypes::*;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_cmd;
    logic [XLEN-1:0]   in_src1;
    logic [XLEN-1:0]   in_src2;
    logic [4:0]        in_rd;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_rd;
    logic [XLEN-1:0]   out_value;
    logic              busy;
    exec_state_e       state_dbg;

    modport master (
        output in_valid, in_cmd, in_src1, in_src2, in_rd, flush, out_ready,
        input  in_ready, out_valid, out_rd, out_value, busy, state_dbg
    );

    modport slave (
        input  in_valid, in_cmd, in_src1, in_src2, in_rd, flush, out_ready,
        output in_ready, out_valid, out_rd, out_value, busy, state_dbg
    );

endinterface

// File: rtl/exec_stage_xlen_iter_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
//   clk, rst    : clock, synchronous active-high reset.
//   start_i     : load dividend_i/divisor_i and begin XLEN iterations.
//   abort_i     : drop the current divide (counter cleared).
//   done_o      : high during the final iteration; quo_o/rem_o then hold the
//                 finished quotient and remainder (combinational next values).
// Operands are magnitudes; sign handling belongs to the caller.
module iter_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [XLEN-1:0]  quo_q, rem_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN:0]    diff;
    logic             fits;
    logic [XLEN-1:0]  quo_nx, rem_nx;

    // Shift the next dividend bit into the partial remainder and try a
    // subtract; the borrow bit decides the quotient bit. The partial
    // remainder needs XLEN+1 bits only for the trial subtraction.
    always_comb begin
        diff   = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
        fits   = ~diff[XLEN];
        rem_nx = fits ? diff[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        quo_nx = {quo_q[XLEN-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (abort_i) begin
            cnt_q <= '0;
        end else if (start_i) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            dvs_q <= divisor_i;
            cnt_q <= CNT_W'(XLEN);
        end else if (cnt_q != '0) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));
    assign quo_o  = quo_nx;
    assign rem_o  = rem_nx;

endmodule

// File: rtl/exec_stage_xlen.sv
// Integer execute stage: single-cycle ALU plus iterative divide, behind a
// one-entry output register.
//   clk, rst : clock, synchronous active-high reset.
//   bus      : exec_stage_xlen_if.slave (op in, result out, flush, busy,
//              state_dbg).
// XLEN must be 32 or 64. ALU ops and divide corner cases (divide by zero,
// signed overflow) complete in one cycle; other divides take XLEN cycles in
// ST_DIV, with the sign fix-up applied here as the result is registered.
module exec_stage_xlen
    import OpTypes::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    exec_stage_xlen_if.slave  bus
);
    localparam int SHAMT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    exec_state_e      state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_value_q, out_value_d;
    logic [4:0]       out_rd_q, out_rd_d;
    logic [4:0]       div_rd_q;
    logic             div_is_rem_q, div_neg_q_q, div_neg_r_q;
    logic             busy_w;

    exec_cmd_e        cmd;
    logic [XLEN-1:0]  a, b;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]  alu_res, special_res, abs_a, abs_b, div_res;
    logic             is_div, is_signed, is_rem, div_zero, div_ovf, special;
    logic             accept, div_start, div_done, div_fin;
    logic [XLEN-1:0]  div_quo, div_rem;

    assign cmd   = exec_cmd_e'(bus.in_cmd);
    assign a     = bus.in_src1;
    assign b     = bus.in_src2;
    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        case (cmd)
            CMD_ADD:  alu_res = a + b;
            CMD_SUB:  alu_res = a - b;
            CMD_SLL:  alu_res = a << shamt;
            CMD_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            CMD_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
            CMD_XOR:  alu_res = a ^ b;
            CMD_SRL:  alu_res = a >> shamt;
            CMD_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            CMD_OR:   alu_res = a | b;
            CMD_AND:  alu_res = a & b;
            default:  alu_res = '0;
        endcase
    end

    // Divide classification; corner cases bypass the iterative divider.
    always_comb begin
        is_div    = (cmd == CMD_DIV) || (cmd == CMD_DIVU) ||
                    (cmd == CMD_REM) || (cmd == CMD_REMU);
        is_signed = (cmd == CMD_DIV) || (cmd == CMD_REM);
        is_rem    = (cmd == CMD_REM) || (cmd == CMD_REMU);
        div_zero  = (b == '0);
        div_ovf   = is_signed && (a == MIN_NEG) && (b == ALL_ONES);
        special   = div_zero || div_ovf;
        if (div_zero)
            special_res = is_rem ? a : ALL_ONES;
        else
            special_res = is_rem ? '0 : a;
        abs_a = (is_signed && a[XLEN-1]) ? -a : a;
        abs_b = (is_signed && b[XLEN-1]) ? -b : b;
    end

    assign bus.in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready) && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign div_start    = accept && is_div && !special;
    assign div_fin      = (state_q == ST_DIV) && div_done && !bus.flush;

    iter_divider #(.XLEN(XLEN)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .abort_i    (bus.flush),
        .dividend_i (abs_a),
        .divisor_i  (abs_b),
        .done_o     (div_done),
        .quo_o      (div_quo),
        .rem_o      (div_rem)
    );

    // Quotient negated when operand signs differ; remainder follows dividend.
    always_comb begin
        if (div_is_rem_q)
            div_res = div_neg_r_q ? -div_rem : div_rem;
        else
            div_res = div_neg_q_q ? -div_quo : div_quo;
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (div_start) state_d = ST_DIV;
            ST_DIV:  if (bus.flush || div_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        busy_w = (state_q == ST_DIV);
    end

    // Output register next value; flush beats every other event. A consume
    // in the same cycle as a load is covered by the load branch.
    always_comb begin
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        out_rd_d    = out_rd_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept && !div_start) begin
            out_valid_d = 1'b1;
            out_value_d = is_div ? special_res : alu_res;
            out_rd_d    = bus.in_rd;
        end else if (div_fin) begin
            out_valid_d = 1'b1;
            out_value_d = div_res;
            out_rd_d    = div_rd_q;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_value_q  <= '0;
            out_rd_q     <= '0;
            div_rd_q     <= '0;
            div_is_rem_q <= 1'b0;
            div_neg_q_q  <= 1'b0;
            div_neg_r_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_rd_q    <= out_rd_d;
            if (div_start) begin
                div_rd_q     <= bus.in_rd;
                div_is_rem_q <= is_rem;
                div_neg_q_q  <= is_signed && (a[XLEN-1] ^ b[XLEN-1]);
                div_neg_r_q  <= is_signed && a[XLEN-1];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_value = out_value_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.busy      = busy_w;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_exec_stage_xlen.sv
// Directed bench for exec_stage_xlen at XLEN=32 and XLEN=64.
module tb_exec_stage_xlen;
    import OpTypes::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exec_stage_xlen_if #(.XLEN(32)) b32 ();
    exec_stage_xlen_if #(.XLEN(64)) b64 ();

    exec_stage_xlen #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    exec_stage_xlen #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue32(input logic [3:0] cmd, input logic [31:0] x, input logic [31:0] y,
                           input logic [4:0] rd);
        b32.in_valid = 1'b1;
        b32.in_cmd   = cmd;
        b32.in_src1  = x;
        b32.in_src2  = y;
        b32.in_rd    = rd;
        #1;
        chk("in_ready32", 64'(b32.in_ready), 64'd1);
        step();
        b32.in_valid = 1'b0;
    endtask

    task automatic issue64(input logic [3:0] cmd, input logic [63:0] x, input logic [63:0] y,
                           input logic [4:0] rd);
        b64.in_valid = 1'b1;
        b64.in_cmd   = cmd;
        b64.in_src1  = x;
        b64.in_src2  = y;
        b64.in_rd    = rd;
        #1;
        chk("in_ready64", 64'(b64.in_ready), 64'd1);
        step();
        b64.in_valid = 1'b0;
    endtask

    // Single-cycle op: result must be present the cycle after acceptance.
    task automatic one32(input string tag, input logic [3:0] cmd, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] rd, input logic [31:0] exp);
        issue32(cmd, x, y, rd);
        chk({tag, "_valid"}, 64'(b32.out_valid), 64'd1);
        chk({tag, "_busy"}, 64'(b32.busy), 64'd0);
        chk(tag, 64'(b32.out_value), 64'(exp));
        chk({tag, "_rd"}, 64'(b32.out_rd), 64'(rd));
    endtask

    // Count cycles from acceptance to out_valid; lat starts at 1 (cycle N+1).
    task automatic wait32(output int lat, output int bcnt);
        lat = 1;
        bcnt = 0;
        while (!b32.out_valid && lat < 200) begin
            if (b32.busy) bcnt++;
            step();
            lat++;
        end
    endtask

    task automatic wait64(output int lat, output int bcnt);
        lat = 1;
        bcnt = 0;
        while (!b64.out_valid && lat < 200) begin
            if (b64.busy) bcnt++;
            step();
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, seen;
        rst = 1'b1;
        b32.in_valid = 0; b32.in_cmd = 0; b32.in_src1 = 0; b32.in_src2 = 0; b32.in_rd = 0;
        b32.flush = 0; b32.out_ready = 1;
        b64.in_valid = 0; b64.in_cmd = 0; b64.in_src1 = 0; b64.in_src2 = 0; b64.in_rd = 0;
        b64.flush = 0; b64.out_ready = 1;
        step();
        step();
        chk("rst_valid", 64'(b32.out_valid), 64'd0);
        chk("rst_value", 64'(b32.out_value), 64'd0);
        chk("rst_rd", 64'(b32.out_rd), 64'd0);
        chk("rst_busy", 64'(b32.busy), 64'd0);
        chk("rst_state", 64'(b32.state_dbg), 64'(ST_IDLE));
        rst = 1'b0;
        step();
        chk("rst_ready", 64'(b32.in_ready), 64'd1);

        // ALU ops
        one32("add",  4'd0, 32'd5, 32'd7, 5'd3, 32'd12);
        one32("sub",  4'd1, 32'd5, 32'd7, 5'd4, 32'hFFFF_FFFE);
        one32("sll",  4'd2, 32'd1, 32'h3F, 5'd5, 32'h8000_0000);
        one32("slt",  4'd3, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd1);
        one32("sltu", 4'd4, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'd0);
        one32("xor",  4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd8, 32'h0FF0_0FF0);
        one32("srl",  4'd6, 32'h8000_0000, 32'h24, 5'd9, 32'h0800_0000);
        one32("sra",  4'd7, 32'h8000_0000, 32'h24, 5'd10, 32'hF800_0000);
        one32("or",   4'd8, 32'hF0, 32'h0F, 5'd11, 32'hFF);
        one32("and",  4'd9, 32'hF0F0, 32'hFF00, 5'd12, 32'hF000);
        one32("undef", 4'd14, 32'd5, 32'd7, 5'd13, 32'd0);

        // Divide corner cases: one cycle, no DIV state
        one32("divu_z", 4'd11, 32'd9, 32'd0, 5'd1, 32'hFFFF_FFFF);
        one32("remu_z", 4'd13, 32'd9, 32'd0, 5'd2, 32'd9);
        one32("div_z",  4'd10, 32'd5, 32'd0, 5'd3, 32'hFFFF_FFFF);
        one32("div_ov", 4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000);
        one32("rem_ov", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'd0);

        // Iterative divides
        issue32(4'd10, 32'hFFFF_FFF9, 32'd2, 5'd7);
        chk("div_ready_busy", 64'(b32.in_ready), 64'd0);
        wait32(lat, bcnt);
        chk("div_lat", 64'(lat), 64'd33);
        chk("div_busycnt", 64'(bcnt), 64'd32);
        chk("div_val", 64'(b32.out_value), 64'h0000_0000_FFFF_FFFD);
        chk("div_rd", 64'(b32.out_rd), 64'd7);
        chk("div_busy_end", 64'(b32.busy), 64'd0);
        issue32(4'd12, 32'hFFFF_FFF9, 32'd2, 5'd8);
        wait32(lat, bcnt);
        chk("rem_lat", 64'(lat), 64'd33);
        chk("rem_val", 64'(b32.out_value), 64'h0000_0000_FFFF_FFFF);
        issue32(4'd11, 32'd100, 32'd7, 5'd9);
        wait32(lat, bcnt);
        chk("divu_val", 64'(b32.out_value), 64'd14);
        issue32(4'd13, 32'd100, 32'd7, 5'd10);
        wait32(lat, bcnt);
        chk("remu_val", 64'(b32.out_value), 64'd2);
        step();

        // Backpressure then back-to-back
        b32.out_ready = 1'b0;
        issue32(4'd0, 32'd1, 32'd2, 5'd20);
        b32.in_valid = 1'b1; b32.in_cmd = 4'd0; b32.in_src1 = 32'd10; b32.in_src2 = 32'd20;
        b32.in_rd = 5'd21;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", 64'(b32.out_valid), 64'd1);
            chk("bp_value", 64'(b32.out_value), 64'd3);
            chk("bp_rd", 64'(b32.out_rd), 64'd20);
            chk("bp_ready", 64'(b32.in_ready), 64'd0);
            step();
        end
        b32.out_ready = 1'b1;
        #1;
        chk("b2b_ready", 64'(b32.in_ready), 64'd1);
        step();
        chk("b2b_v1", 64'(b32.out_value), 64'd30);
        chk("b2b_rd1", 64'(b32.out_rd), 64'd21);
        b32.in_src1 = 32'd100; b32.in_src2 = 32'd1; b32.in_rd = 5'd22;
        step();
        chk("b2b_v2", 64'(b32.out_value), 64'd101);
        chk("b2b_valid2", 64'(b32.out_valid), 64'd1);
        b32.in_src1 = 32'd7; b32.in_src2 = 32'd8; b32.in_rd = 5'd23;
        step();
        chk("b2b_v3", 64'(b32.out_value), 64'd15);
        b32.in_valid = 1'b0;
        step();
        chk("b2b_drain", 64'(b32.out_valid), 64'd0);

        // Flush mid-divide, with a competing op in the flush cycle
        issue32(4'd10, 32'd100, 32'd7, 5'd24);
        for (int i = 0; i < 9; i++) step();
        chk("fl_busy_pre", 64'(b32.busy), 64'd1);
        b32.flush = 1'b1;
        b32.in_valid = 1'b1; b32.in_cmd = 4'd0; b32.in_src1 = 32'd1; b32.in_src2 = 32'd1;
        #1;
        chk("fl_ready", 64'(b32.in_ready), 64'd0);
        step();
        b32.flush = 1'b0;
        b32.in_valid = 1'b0;
        #1;
        chk("fl_valid", 64'(b32.out_valid), 64'd0);
        chk("fl_busy", 64'(b32.busy), 64'd0);
        chk("fl_ready_after", 64'(b32.in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (b32.out_valid) seen++;
        end
        chk("fl_no_result", 64'(seen), 64'd0);

        // Reset mid-divide
        issue32(4'd10, 32'd100, 32'd7, 5'd25);
        for (int i = 0; i < 9; i++) step();
        chk("rs_busy_pre", 64'(b32.busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rs_busy", 64'(b32.busy), 64'd0);
        chk("rs_valid", 64'(b32.out_valid), 64'd0);
        chk("rs_value", 64'(b32.out_value), 64'd0);
        chk("rs_ready", 64'(b32.in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (b32.out_valid) seen++;
        end
        chk("rs_no_result", 64'(seen), 64'd0);

        // XLEN=64
        issue64(4'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd2);
        wait64(lat, bcnt);
        chk("d64_lat", 64'(lat), 64'd65);
        chk("d64_busycnt", 64'(bcnt), 64'd64);
        chk("d64_val", b64.out_value, 64'h5555_5555_5555_5555);
        issue64(4'd2, 64'd1, 64'h41, 5'd3);
        chk("sll64_valid", 64'(b64.out_valid), 64'd1);
        chk("sll64", b64.out_value, 64'd2);
        issue64(4'd7, 64'h8000_0000_0000_0000, 64'h3F, 5'd4);
        chk("sra64", b64.out_value, 64'hFFFF_FFFF_FFFF_FFFF);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_stage_xlen.md
EXEC_STAGE_XLEN -- requirements
Module: exec_stage_xlen

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 Parameter: SHAMT_W, default $clog2(XLEN), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream op present.
REQ-006 in_ready  output  1  stage accepts op this cycle.
REQ-007 in_cmd  input  4  ExecCmd operation code.
REQ-008 in_src1  input  XLEN  operand 1.
REQ-009 in_src2  input  XLEN  operand 2.
REQ-010 in_rd  input  5  destination register tag, passed through.
REQ-011 flush  input  1  kill in-flight and buffered op.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  downstream consumes result.
REQ-014 out_rd  output  5  tag of presented result.
REQ-015 out_value  output  XLEN  result of presented op.
REQ-016 busy  output  1  divider iterating.

Function
REQ-017 ExecCmd SHALL encode ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, DIV, DIVU, REM, REMU; unlisted codes SHALL produce result 0 with single-cycle latency.
REQ-018 Shifts SHALL use src2[SHAMT_W-1:0] only; SRA sign-extends; SLT/SLTU return 1 or 0 zero-extended.
REQ-019 Handshake: op accepted when in_valid && in_ready; result consumed when out_valid && out_ready.
REQ-020 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-021 ALU ops and divide special cases accepted in cycle N SHALL present out_valid in cycle N+1.
REQ-022 Normal divides SHALL enter state DIV, iterate one quotient bit per cycle (restoring, on magnitudes), present out_valid in cycle N+XLEN+1, then return to IDLE.
REQ-023 Signed divide: quotient negated iff operand signs differ; remainder takes dividend sign.
REQ-024 Divide by zero: DIV/DIVU result all-ones; REM/REMU result = src1; no DIV state entered.
REQ-025 Signed overflow (src1 = most-negative, src2 = -1): DIV result src1, REM result 0; no DIV state.
REQ-026 Output register SHALL hold out_value/out_rd stable while out_valid && !out_ready.
REQ-027 Consume and accept in same cycle SHALL be lossless: new result replaces old in the next cycle, no bubble.
REQ-028 flush SHALL, next cycle: clear out_valid, abort any divide to IDLE, discard same-cycle in_valid; flush has priority over every other event.
REQ-029 busy SHALL be 1 exactly while state==DIV.
REQ-030 States: IDLE, DIV only; DIV->IDLE on final iteration, flush, or rst.

Reset
REQ-031 rst SHALL force state IDLE, out_valid 0, out_value 0, out_rd 0, busy 0, divider counter 0.
REQ-032 rst mid-divide SHALL abandon the op with no result produced; in_ready 1 the cycle after rst deasserts.

Structure
REQ-033 ExecCmd enum SHALL reside in shared package OpTypes; XLEN-derived widths stay local parameters.
REQ-034 Iterative divider SHALL be sub-module iter_divider (parameter XLEN; start/abort/done handshake; magnitude quotient and remainder out).
REQ-035 Sign fix-up, special-case detection and output register SHALL remain in exec_stage_xlen.

Verification
REQ-036 XLEN=32: ADD 5,7 at cycle N -> out_value 12 at N+1; SRA 0x80000000,0x24 -> 0xF8000000 (shift 4).
REQ-037 XLEN=32: DIV 0xFFFFFFF9,2 -> 0xFFFFFFFD at N+33, busy high 32 cycles; REM same operands -> 0xFFFFFFFF.
REQ-038 XLEN=32: DIVU 9,0 -> 0xFFFFFFFF at N+1; REMU 9,0 -> 9; DIV 0x80000000,0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-039 out_ready low 3 cycles after out_valid -> out_value stable, in_ready 0; out_ready high with in_valid -> back-to-back ADDs 1 result per cycle.
REQ-040 flush 10 cycles into DIV -> no out_valid, busy 0 and in_ready 1 next cycle; rst mid-divide identical.
REQ-041 XLEN=64: DIVU 0xFFFFFFFFFFFFFFFF,3 -> 0x5555555555555555 at N+65; SLL 1,0x41 -> 2.
